// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: field positions,
// per-format address widths, opcode format boundaries and the load-state enum.
package isa_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 29;
    localparam int R0_HI  = 28;
    localparam int R0_LO  = 24;
    localparam int R1_HI  = 23;
    localparam int R1_LO  = 19;
    localparam int R2_HI  = 18;
    localparam int R2_LO  = 14;

    localparam int ADDR_W_FMT_A = 16;
    localparam int ADDR_W_FMT_B = 15;
    localparam int ADDR_W_FMT_C = 14;

    // Opcodes 0..1 are format A, 2..3 format B, 4..7 format C.
    localparam logic [2:0] OPC_FMT_A_LAST = 3'd1;
    localparam logic [2:0] OPC_FMT_B_LAST = 3'd3;

    typedef enum logic [1:0] {
        FMT_A,
        FMT_B,
        FMT_C
    } inst_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } load_state_e;

    function automatic inst_fmt_e opc_fmt(input logic [2:0] opc);
        if (opc <= OPC_FMT_A_LAST) begin
            return FMT_A;
        end else if (opc <= OPC_FMT_B_LAST) begin
            return FMT_B;
        end
        return FMT_C;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: builds the 32-bit ISA word from its fields and flags
// an address/immediate that does not fit the format's address field.
module inst_pack
    import isa_pkg::*;
(
    input  logic [2:0]  opcode_i,
    input  logic [4:0]  reg_addr_0_i,
    input  logic [4:0]  reg_addr_1_i,
    input  logic [4:0]  reg_addr_2_i,
    input  logic [15:0] addr_i,
    output logic [31:0] inst_o,
    output logic        range_err_o
);

    // Field placement by opcode format; unused register inputs are ignored.
    always_comb begin
        inst_o                 = '0;
        range_err_o            = 1'b0;
        inst_o[OPC_HI:OPC_LO]  = opcode_i;
        inst_o[R0_HI:R0_LO]    = reg_addr_0_i;
        case (opc_fmt(opcode_i))
            FMT_A: begin
                inst_o[ADDR_W_FMT_A-1:0] = addr_i;
            end
            FMT_B: begin
                inst_o[R1_HI:R1_LO]      = reg_addr_1_i;
                inst_o[ADDR_W_FMT_B-1:0] = addr_i[ADDR_W_FMT_B-1:0];
                range_err_o              = |addr_i[15:ADDR_W_FMT_B];
            end
            default: begin
                inst_o[R1_HI:R1_LO]      = reg_addr_1_i;
                inst_o[R2_HI:R2_LO]      = reg_addr_2_i;
                inst_o[ADDR_W_FMT_C-1:0] = addr_i[ADDR_W_FMT_C-1:0];
                range_err_o              = |addr_i[15:ADDR_W_FMT_C];
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder and program loader. Accepts instruction fields over a
// valid/ready handshake, packs them and writes the words to consecutive
// instruction-memory addresses starting at a programmed base.
// Optional feature: ENC_RANGE_CHECK_EN drops out-of-range fields and raises
// the sticky enc_err flag; without it the address is truncated silently.
//
// state   | meaning
// IDLE    | after reset, nothing accepted
// LOAD    | session open, accepting fields and writing words
// DONE    | all words of the session written; waits for next load_start
module inst_encoder
    import isa_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int CNT_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic [IMEM_AW-1:0] load_base,
    input  logic [CNT_W-1:0]   load_count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [4:0]         reg_addr_0,
    input  logic [4:0]         reg_addr_1,
    input  logic [4:0]         reg_addr_2,
    input  logic [15:0]        addr,
    output logic               imem_we,
    input  logic               imem_ready,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               load_busy,
    output logic               load_done,
    output logic               enc_err
);

    load_state_e        state_q, state_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]   acc_left_q, acc_left_d;
    logic [CNT_W-1:0]   wr_left_q, wr_left_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;

    logic [31:0]        packed_inst;
    logic               range_err;
    logic               range_bad;
    logic               xfer;
    logic               wr_done;

    inst_pack u_pack (
        .opcode_i     (opcode),
        .reg_addr_0_i (reg_addr_0),
        .reg_addr_1_i (reg_addr_1),
        .reg_addr_2_i (reg_addr_2),
        .addr_i       (addr),
        .inst_o       (packed_inst),
        .range_err_o  (range_err)
    );

`ifdef ENC_RANGE_CHECK_EN
    assign range_bad = range_err;
`else
    logic unused_range_err;
    assign unused_range_err = range_err;
    assign range_bad        = 1'b0;
`endif

    // The output register may be refilled in the same cycle it drains.
    assign in_ready = (state_q == ST_LOAD) && (acc_left_q != '0) && (!we_q || imem_ready);
    assign xfer     = in_valid && in_ready;
    assign wr_done  = we_q && imem_ready;

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign load_busy  = (state_q == ST_LOAD);
    assign load_done  = (state_q == ST_DONE);
    assign enc_err    = err_q;

    // Next-state, counters and output-register update.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        acc_left_d = acc_left_q;
        wr_left_d  = wr_left_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        case (state_q)
            ST_LOAD: begin
                if (wr_done) begin
                    we_d      = 1'b0;
                    addr_d    = addr_q + IMEM_AW'(1);
                    wr_left_d = wr_left_q - CNT_W'(1);
                    if (wr_left_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                if (xfer) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        we_d       = 1'b1;
                        wdata_d    = packed_inst;
                        acc_left_d = acc_left_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                if (load_start) begin
                    err_d = 1'b0;
                    if (load_count != '0) begin
                        state_d    = ST_LOAD;
                        addr_d     = load_base;
                        acc_left_d = load_count;
                        wr_left_d  = load_count;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset abandons any partial session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            acc_left_q <= '0;
            wr_left_q  <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            acc_left_q <= acc_left_d;
            wr_left_q  <= wr_left_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

endmodule
